// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, opcode and PC constants.
// Related build option: FETCH_ALIGN_CHECK_EN (enables misaligned-redirect trapping in instr_fetch).
package instr_fetch_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned OPC_W     = 6;
    localparam int unsigned J_IMM_W   = 26;

    localparam logic [OPC_W-1:0] OP_J    = 6'd2;
    localparam logic [XLEN-1:0]  PC_INCR = 32'd4;

    // Low two bits of a byte address; fetches are word aligned.
    localparam logic [XLEN-1:0] ALIGN_MASK  = 32'hFFFF_FFFC;
    localparam logic [XLEN-1:0] REGION_MASK = 32'hF000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_ERR   = 2'd3
    } fetch_state_e;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [XLEN-1:0] word);
        return word[XLEN-1 -: OPC_W];
    endfunction

    // Jump target keeps the 256 MB region of the sequential successor.
    function automatic logic [XLEN-1:0] j_target(input logic [XLEN-1:0] pc_plus4,
                                                 input logic [XLEN-1:0] word);
        logic [XLEN-1:0] imm_part;
        imm_part = {4'b0000, word[J_IMM_W-1:0], 2'b00};
        return (pc_plus4 & REGION_MASK) | (imm_part & ~REGION_MASK);
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection for the fetch stage: redirect > J target > PC+4 > hold.
module pc_next_sel
    import instr_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr_word,
    input  logic        advance,
    input  logic        redirect_take,
    input  logic [31:0] redirect_target,
    output logic [31:0] next_pc_c
);

    logic [31:0] pc_plus4;
    logic        is_jump;

    // Sequential successor wraps naturally at 2^32.
    assign pc_plus4 = pc + PC_INCR;
    assign is_jump  = (opcode_of(instr_word) == OP_J);

    always_comb begin
        next_pc_c = pc;
        if (redirect_take) begin
            next_pc_c = redirect_target;
        end else if (advance && is_jump) begin
            next_pc_c = j_target(pc_plus4, instr_word);
        end else if (advance) begin
            next_pc_c = pc_plus4;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Single-issue instruction fetch stage with valid/ready output, J fast-path and redirect.
// Build option FETCH_ALIGN_CHECK_EN: misaligned redirects trap into a sticky ERR state.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic        fetch_err
);

    fetch_state_e state, state_next;

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] redirect_target;
    logic        redirect_misaligned;
    logic        redirect_req;
    logic        redirect_take;
    logic        err_take;
    logic        latch_en;
    logic        valid_clr;

    // Memory address comes straight from the PC flop.
    assign imem_addr = pc;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_misaligned = (redirect_addr[1:0] != 2'b00);
    assign redirect_target     = redirect_addr;
`else
    assign redirect_misaligned = 1'b0;
    assign redirect_target     = redirect_addr & ALIGN_MASK;
`endif

    // ERR is terminal until reset, so redirects are ignored there.
    assign redirect_req  = redirect_valid && (state != ST_ERR);
    assign redirect_take = redirect_req && !redirect_misaligned;
    assign err_take      = redirect_req && redirect_misaligned;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (err_take) begin
            state_next = ST_ERR;
        end else if (redirect_take) begin
            state_next = ST_RUN;
        end else begin
            unique case (state)
                ST_IDLE:  state_next = ST_RUN;
                ST_RUN:   if (instr_valid && !instr_ready) state_next = ST_STALL;
                ST_STALL: if (instr_ready) state_next = ST_RUN;
                ST_ERR:   state_next = ST_ERR;
                default:  state_next = ST_IDLE;
            endcase
        end
    end

    // A new word is captured whenever the output slot is empty or being consumed.
    always_comb begin
        latch_en  = 1'b0;
        valid_clr = 1'b0;
        if (redirect_req) begin
            valid_clr = 1'b1;
        end else if ((state == ST_RUN) || (state == ST_STALL)) begin
            latch_en = !instr_valid || instr_ready;
        end
    end

    pc_next_sel u_pc_next_sel (
        .pc              (pc),
        .instr_word      (imem_data),
        .advance         (latch_en),
        .redirect_take   (redirect_take),
        .redirect_target (redirect_target),
        .next_pc_c       (pc_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_valid <= 1'b0;
            instr_data  <= 32'd0;
            instr_pc    <= 32'd0;
        end else if (valid_clr) begin
            instr_valid <= 1'b0;
        end else if (latch_en) begin
            instr_valid <= 1'b1;
            instr_data  <= imem_data;
            instr_pc    <= pc;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_err <= 1'b0;
        end else if (err_take) begin
            fetch_err <= 1'b1;
        end
    end
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd0: byte address of the first fetch after reset.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port imem_addr, output, 32: byte address driven to the combinational instruction memory.
REQ-005 SHALL have port imem_data, input, 32: instruction word returned by memory in the same cycle.
REQ-006 SHALL have port redirect_valid, input, 1: external PC redirect request (branch/exception).
REQ-007 SHALL have port redirect_addr, input, 32: redirect target byte address.
REQ-008 SHALL have port instr_valid, output, 1: instr_data/instr_pc hold a valid instruction.
REQ-009 SHALL have port instr_ready, input, 1: consumer accepts the instruction this cycle.
REQ-010 SHALL have port instr_data, output, 32: latched instruction word.
REQ-011 SHALL have port instr_pc, output, 32: byte address of instr_data.
REQ-012 SHALL have port fetch_err, output, 1: sticky alignment error flag.

Function
REQ-013 SHALL drive imem_addr directly from the internal PC register, with no combinational path from inputs.
REQ-014 SHALL implement states IDLE, RUN, STALL and ERR.
REQ-015 SHALL enter IDLE on reset, output instr_valid=0, and move to RUN on the next edge without latching.
REQ-016 In RUN, each edge SHALL latch instr_data<=imem_data, instr_pc<=PC and instr_valid<=1, then advance the PC (one-cycle latency, one instruction per cycle).
REQ-017 SHALL define an instruction transfer as instr_valid & instr_ready.
REQ-018 When instr_valid=1 and instr_ready=0, SHALL enter STALL and hold PC, instr_data, instr_pc and instr_valid unchanged.
REQ-019 SHALL leave STALL on the edge where instr_ready=1, latching the instruction at the held PC.
REQ-020 Next PC SHALL default to PC+4 modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000.
REQ-021 SHALL decode the J opcode (imem_data[31:26]==6'd2) while latching and set next PC = {PC+4[31:28], imem_data[25:0], 2'b00}, giving zero bubbles; the J word itself SHALL still be delivered.
REQ-022 redirect_valid SHALL take priority over J decode, stall and sequential advance.
REQ-023 On redirect, the next edge SHALL set PC<=redirect_addr, set instr_valid<=0 (discarding any held instruction, including in STALL), and enter RUN.
REQ-024 Opcode 6'd0 (including all-zero words) SHALL be passed through as a normal instruction.

Reset
REQ-025 Reset SHALL set PC=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0, fetch_err=0 and state=IDLE.
REQ-026 Reset asserted in any state, including STALL and ERR, SHALL abort and apply REQ-025 immediately.

Configuration
REQ-027 With macro FETCH_ALIGN_CHECK_EN defined, a redirect with redirect_addr[1:0]!=0 SHALL set fetch_err=1, instr_valid=0 and enter ERR, which only reset exits.
REQ-028 In ERR, PC SHALL freeze at the last aligned value.
REQ-029 Without FETCH_ALIGN_CHECK_EN, redirect_addr[1:0] SHALL be forced to 2'b00 and fetch_err SHALL be tied to 0.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the opcode constant OP_J=6'd2, and the constant PC_INCR=32'd4.
REQ-031 Next-PC selection (redirect > J > +4 > hold) SHALL be one sub-module, pc_next_sel; the FSM and output registers stay in instr_fetch.

Verification
REQ-032 Memory program {lw; add; j 7; add; 0; 0; 0; add; add} with instr_ready=1 -> instr_pc sequence 0x0, 0x4, 0x8, 0x1C, 0x20; 0xC never appears.
REQ-033 Hold instr_ready=0 for 3 cycles while instr_pc=0x4 -> imem_addr, instr_pc and instr_data stable for 3 cycles; 0x8 follows on release.
REQ-034 redirect_valid=1 with redirect_addr=0x40 during STALL -> next cycle instr_valid=0, imem_addr=0x40; the following cycle instr_pc=0x40.
REQ-035 redirect_addr=0xFFFFFFFC -> delivered PCs 0xFFFFFFFC then 0x00000000.
REQ-036 With FETCH_ALIGN_CHECK_EN, redirect_addr=0x42 -> fetch_err=1, instr_valid=0 until reset; without it, the fetch proceeds from 0x40.
REQ-037 Assert reset asynchronously mid-stream -> outputs at reset values without waiting for a clock edge; first post-reset instr_pc=RESET_PC.
